tt_puf_sequencer: RTL

//  Drives one key-switched race chain with a NAND-latch output: key_4 in, pulse in, multblockout out.
//  For each of N_BITS challenges it:
//   - applies a 4-bit key;
//   - launches pulse edges VOTES times;
//   - samples the latch output each time and majority-votes the result into one response bit.

---
 rtl/tt_puf_sequencer_if.sv | 25 ++
 rtl/tt_puf_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tt_puf_sequencer_if.sv
// Control-pin and race-chain signal bundle for tt_puf_sequencer.
// The master side is the chip-level controller/environment; the slave side is the sequencer.
interface tt_puf_sequencer_if #(
  parameter int N_BITS = 8
);
  logic              start;
  logic              abort;
  logic [3:0]        seed;
  logic              multblockout;
  logic [3:0]        key_4;
  logic              pulse;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] response;

  modport master (
    output start, abort, seed, multblockout,
    input  key_4, pulse, busy, done, response
  );

  modport slave (
    input  start, abort, seed, multblockout,
    output key_4, pulse, busy, done, response
  );
endinterface

// File: rtl/tt_puf_sequencer.sv
// Race-chain PUF sequencer: per challenge, applies a key, fires VOTES launches and
// majority-votes the synchronised latch output into one response bit.
module tt_puf_sequencer #(
  parameter int N_BITS     = 8,
  parameter int ARM_CYC    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int VOTES      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_puf_sequencer_if.slave  bus
);

  localparam int KW   = $clog2(N_BITS) + 1;
  localparam int TMAX = (ARM_CYC > SETTLE_CYC) ? ARM_CYC : SETTLE_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [KW-1:0]     k_q, k_d;
  logic [2:0]        vote_q, vote_d;
  logic [2:0]        ones_q, ones_d;
  logic [3:0]        seed_q, seed_d;
  logic [3:0]        key_q, key_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic              sync1_q, sync2_q;

  logic              s_out;
  logic [2:0]        ones_nxt;
  logic              maj;
  logic [KW-1:0]     k_inc;

  // multblockout is asynchronous to clk; only the second flop is ever consumed
  assign s_out    = sync2_q;
  assign ones_nxt = ones_q + {2'b00, s_out};
  assign maj      = (ones_nxt > 3'(VOTES / 2));
  assign k_inc    = k_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    k_d     = k_q;
    vote_d  = vote_q;
    ones_d  = ones_q;
    seed_d  = seed_q;
    key_d   = key_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          seed_d  = bus.seed;
          k_d     = '0;
          vote_d  = '0;
          ones_d  = '0;
          tmr_d   = '0;
          key_d   = bus.seed;
          resp_d  = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (tmr_q == TW'(ARM_CYC - 1)) begin
          tmr_d   = '0;
          state_d = S_FIRE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_FIRE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (tmr_q == TW'(SETTLE_CYC - 1)) begin
          tmr_d = '0;
          if (vote_q < 3'(VOTES - 1)) begin
            vote_d  = vote_q + 1'b1;
            ones_d  = ones_nxt;
            state_d = S_ARM;
          end else begin
            for (int i = 0; i < N_BITS; i++) begin
              if (k_q == KW'(i)) resp_d[i] = maj;
            end
            vote_d = '0;
            ones_d = '0;
            if (k_q < KW'(N_BITS - 1)) begin
              k_d     = k_inc;
              key_d   = seed_q ^ 4'(k_inc);
              state_d = S_ARM;
            end else begin
              state_d = S_DONE;
            end
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cancelling a run discards any partial response and wins over a final-vote sample
    if (bus.abort && (state_q == S_ARM || state_q == S_FIRE)) begin
      tmr_d  = '0;
      vote_d = '0;
      ones_d = '0;
      resp_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      k_q     <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      seed_q  <= '0;
      key_q   <= '0;
      resp_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      k_q     <= k_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      seed_q  <= seed_d;
      key_q   <= key_d;
      resp_q  <= resp_d;
      sync1_q <= bus.multblockout;
      sync2_q <= sync1_q;
    end
  end

  assign bus.key_4    = key_q;
  assign bus.pulse    = (state_q == S_FIRE);
  assign bus.busy     = (state_q == S_ARM) || (state_q == S_FIRE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.response = resp_q;

endmodule
